// File: rtl/stream_to_axi_r.sv
// rtl/stream_to_axi_r.sv - rebuilds AXI R-channel beats from a framed capture stream
// (one header beat carrying type and rid, then data beats) through a 2-entry skid buffer.
module stream_to_axi_r #(
  parameter int                           DATA_WIDTH        = 128,
  parameter int                           ID_WIDTH          = 32,
  parameter int                           USER_WIDTH        = 64,
  parameter int                           STREAM_TYPE_WIDTH = 3,
  parameter logic [STREAM_TYPE_WIDTH-1:0] STREAM_TYPE       = 3'b0,
  parameter int                           MAX_BEATS         = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  s_last,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic [1:0]            s_resp,
  output logic [ID_WIDTH-1:0]   AXIM_rid,
  output logic [DATA_WIDTH-1:0] AXIM_rdata,
  output logic [1:0]            AXIM_rresp,
  output logic                  AXIM_rlast,
  output logic [USER_WIDTH-1:0] AXIM_ruser,
  output logic                  AXIM_rvalid,
  input  logic                  AXIM_rready,
  output logic [15:0]           frame_count,
  output logic [15:0]           beat_count,
  output logic [15:0]           drop_count
);

  localparam int IDX_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MAX_BEATS - 1);

  typedef enum logic [1:0] {HDR, DATA, DROP} state_t;

  state_t                 state, state_nxt;
  logic [IDX_W-1:0]       idx, idx_nxt;
  logic [ID_WIDTH-1:0]    rid_q, rid_nxt;

  logic                   hs;
  logic                   pop;
  logic                   push;
  logic                   frame_inc;
  logic                   drop_inc;
  logic                   last_idx;
  logic                   in_rlast;
  logic [STREAM_TYPE_WIDTH-1:0] hdr_type;

  // skid buffer: head drives AXIM_*, tail holds the overflow beat
  logic [1:0]             cnt, cnt_nxt;
  logic                   load_head_in;
  logic                   load_tail_in;
  logic                   head_from_tail;
  logic [ID_WIDTH-1:0]    tail_rid;
  logic [DATA_WIDTH-1:0]  tail_data;
  logic [1:0]             tail_resp;
  logic                   tail_last;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign hs         = s_valid && s_ready;
  assign pop        = AXIM_rvalid && AXIM_rready;
  assign hdr_type   = s_data[DATA_WIDTH-1 -: STREAM_TYPE_WIDTH];
  assign last_idx   = (idx == IDX_LAST);
  assign in_rlast   = s_last || last_idx;
  assign AXIM_ruser = '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= HDR;
      idx   <= '0;
      rid_q <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      rid_q <= rid_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    rid_nxt   = rid_q;
    push      = 1'b0;
    frame_inc = 1'b0;
    drop_inc  = 1'b0;
    case (state)
      HDR: begin
        if (hs) begin
          if (s_last) begin
            drop_inc = 1'b1;
          end else if (hdr_type == STREAM_TYPE) begin
            rid_nxt   = s_data[ID_WIDTH-1:0];
            idx_nxt   = '0;
            state_nxt = DATA;
          end else begin
            drop_inc  = 1'b1;
            state_nxt = DROP;
          end
        end
      end
      DATA: begin
        if (hs) begin
          push    = 1'b1;
          idx_nxt = idx + IDX_W'(1);
          if (s_last) begin
            frame_inc = 1'b1;
            state_nxt = HDR;
          end else if (last_idx) begin
            // burst limit reached: close the burst here, discard the rest of the frame
            drop_inc  = 1'b1;
            state_nxt = DROP;
          end
        end
      end
      DROP: begin
        if (hs && s_last) begin
          state_nxt = HDR;
        end
      end
      default: state_nxt = HDR;
    endcase
  end

  always_comb begin
    cnt_nxt        = cnt;
    load_head_in   = 1'b0;
    load_tail_in   = 1'b0;
    head_from_tail = 1'b0;
    case (cnt)
      2'd0: begin
        if (push) begin
          load_head_in = 1'b1;
          cnt_nxt      = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          load_head_in = 1'b1;
        end else if (push) begin
          load_tail_in = 1'b1;
          cnt_nxt      = 2'd2;
        end else if (pop) begin
          cnt_nxt = 2'd0;
        end
      end
      default: begin
        // s_ready is low while full, so no push can arrive here
        if (pop) begin
          head_from_tail = 1'b1;
          cnt_nxt        = 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= 2'd0;
      s_ready     <= 1'b1;
      AXIM_rvalid <= 1'b0;
      AXIM_rid    <= '0;
      AXIM_rdata  <= '0;
      AXIM_rresp  <= 2'b00;
      AXIM_rlast  <= 1'b0;
      tail_rid    <= '0;
      tail_data   <= '0;
      tail_resp   <= 2'b00;
      tail_last   <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      s_ready     <= (cnt_nxt != 2'd2);
      AXIM_rvalid <= (cnt_nxt != 2'd0);
      if (load_head_in) begin
        AXIM_rid   <= rid_q;
        AXIM_rdata <= s_data;
        AXIM_rresp <= s_resp;
        AXIM_rlast <= in_rlast;
      end else if (head_from_tail) begin
        AXIM_rid   <= tail_rid;
        AXIM_rdata <= tail_data;
        AXIM_rresp <= tail_resp;
        AXIM_rlast <= tail_last;
      end
      if (load_tail_in) begin
        tail_rid  <= rid_q;
        tail_data <= s_data;
        tail_resp <= s_resp;
        tail_last <= in_rlast;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_count <= 16'd0;
      beat_count  <= 16'd0;
      drop_count  <= 16'd0;
    end else begin
      if (frame_inc) frame_count <= sat_inc(frame_count);
      if (pop)       beat_count  <= sat_inc(beat_count);
      if (drop_inc)  drop_count  <= sat_inc(drop_count);
    end
  end

endmodule
